// File: rtl/alu_sched_pkg.sv
// Shared constants and FSM encoding for the ALU APB scheduler.
// The CSR map and CTRL word layout match the shared alu_top_module.
package alu_sched_pkg;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam int unsigned REG_CTRL = 0;
  localparam int unsigned REG_0    = 1;
  localparam int unsigned REG_1    = 2;
  localparam int unsigned REG_RES  = 3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_OP_LSB    = 1;
  localparam int unsigned CTRL_ID_LSB    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_WR_A,
    S_WR_B,
    S_WR_CTRL,
    S_RD_RES,
    S_BACKOFF
  } state_t;

endpackage

// File: rtl/alu_apb_scheduler_rr_arbiter.sv
// Pointer-based round-robin arbiter: the first active request at or after ptr
// wins, and the grant is one-hot.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // NUM_REQ is a power of two, so the index wraps naturally
      cand = ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_apb_scheduler.sv
// APB master front-end that time-shares one ALU between NUM_REQ requesters,
// tagging each job with an owner ID and routing read-back results by that ID.
module alu_apb_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned APB_BUS_SIZE = 32,
  parameter int unsigned ADDRESS_SIZE = 2,
  parameter int unsigned DATA_SIZE    = 16,
  parameter int unsigned ID_SIZE      = 8,
  parameter int unsigned MAX_OUTSTAND = 4,
  parameter int unsigned RETRY_GAP    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*2-1:0]           req_op,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_a,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_b,
  output logic [NUM_REQ-1:0]             res_valid,
  output logic [DATA_SIZE-1:0]           res_data,
  output logic                           res_carry,
  output logic [ID_SIZE-1:0]             res_id,
  output logic                           err_pulse,
  output logic                           sel,
  output logic                           en,
  output logic                           write,
  output logic [ADDRESS_SIZE-1:0]        addr,
  output logic [APB_BUS_SIZE-1:0]        wdata,
  input  logic [APB_BUS_SIZE-1:0]        rdata,
  input  logic                           ready,
  input  logic                           slv_err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned SEQ_W = ID_SIZE - IDX_W;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTAND + 1);
  localparam int unsigned GAP_W = $clog2(RETRY_GAP + 1);

  state_t             state, next_state;
  logic               phase, toggle;
  logic [IDX_W-1:0]   rr_ptr, job_idx, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any, grant_legal;
  logic [1:0]         job_op, grant_op;
  logic [DATA_SIZE-1:0] job_a, job_b;
  logic [SEQ_W-1:0]   seq [NUM_REQ];
  logic [CNT_W-1:0]   outstanding;
  logic [GAP_W-1:0]   gap_cnt;
  logic               bus_state, done, have_req, have_out, full;
  logic [ID_SIZE-1:0] job_id, rd_id;
  logic               unused_rdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign have_req     = |req_valid;
  assign have_out     = outstanding != '0;
  assign full         = outstanding == CNT_W'(MAX_OUTSTAND);
  assign bus_state    = state inside {S_WR_A, S_WR_B, S_WR_CTRL, S_RD_RES};
  assign done         = bus_state && phase && ready;
  assign grant_op     = req_op[grant_idx*2 +: 2];
  assign grant_legal  = grant_op inside {OP_ADD, OP_MUL};
  assign job_id       = {job_idx, seq[job_idx]};
  assign rd_id        = rdata[DATA_SIZE+1 +: ID_SIZE];
  assign unused_rdata = ^rdata[APB_BUS_SIZE-1:DATA_SIZE+ID_SIZE+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (full)                      next_state = S_RD_RES;
        else if (have_req && have_out) next_state = toggle ? S_RD_RES : S_ARB;
        else if (have_req)             next_state = S_ARB;
        else if (have_out)             next_state = S_RD_RES;
      end
      S_ARB:     next_state = (grant_any && grant_legal) ? S_WR_A : S_IDLE;
      S_WR_A:    if (done) next_state = slv_err ? S_IDLE : S_WR_B;
      S_WR_B:    if (done) next_state = slv_err ? S_IDLE : S_WR_CTRL;
      S_WR_CTRL: if (done) next_state = S_IDLE;
      S_RD_RES:  if (done) next_state = slv_err ? S_BACKOFF : S_IDLE;
      S_BACKOFF: if (gap_cnt == '0) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    sel   = bus_state;
    en    = bus_state && phase;
    write = state inside {S_WR_A, S_WR_B, S_WR_CTRL};
    addr  = '0;
    wdata = '0;
    case (state)
      S_WR_A: begin
        addr  = ADDRESS_SIZE'(REG_0);
        wdata = APB_BUS_SIZE'(job_a);
      end
      S_WR_B: begin
        addr  = ADDRESS_SIZE'(REG_1);
        wdata = APB_BUS_SIZE'(job_b);
      end
      S_WR_CTRL: begin
        addr                              = ADDRESS_SIZE'(REG_CTRL);
        wdata[CTRL_ID_LSB +: ID_SIZE]     = job_id;
        wdata[CTRL_OP_LSB +: 2]           = job_op;
        wdata[CTRL_START_BIT]             = 1'b1;
      end
      S_RD_RES: addr = ADDRESS_SIZE'(REG_RES);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= 1'b0;
      toggle      <= 1'b0;
      rr_ptr      <= '0;
      job_idx     <= '0;
      job_op      <= '0;
      job_a       <= '0;
      job_b       <= '0;
      outstanding <= '0;
      gap_cnt     <= '0;
      req_ready   <= '0;
      res_valid   <= '0;
      res_data    <= '0;
      res_carry   <= 1'b0;
      res_id      <= '0;
      err_pulse   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) seq[i] <= '0;
    end else begin
      req_ready <= '0;
      res_valid <= '0;
      err_pulse <= 1'b0;
      phase     <= bus_state && !done;

      if (state == S_IDLE && have_req && have_out && !full) toggle <= ~toggle;

      if (state == S_ARB && grant_any) begin
        rr_ptr  <= grant_idx + 1'b1;
        job_idx <= grant_idx;
        job_op  <= grant_op;
        job_a   <= req_a[grant_idx*DATA_SIZE +: DATA_SIZE];
        job_b   <= req_b[grant_idx*DATA_SIZE +: DATA_SIZE];
        if (!grant_legal) begin
          req_ready <= grant;
          err_pulse <= 1'b1;
        end
      end

      // A failed write abandons the job but still releases the requester
      if (done && write) begin
        if (slv_err) begin
          err_pulse          <= 1'b1;
          req_ready[job_idx] <= 1'b1;
        end else if (state == S_WR_CTRL) begin
          req_ready[job_idx] <= 1'b1;
          outstanding        <= outstanding + 1'b1;
          seq[job_idx]       <= seq[job_idx] + 1'b1;
        end
      end

      // BACKOFF lasts RETRY_GAP-1 cycles; the following IDLE cycle completes the gap
      if (done && state == S_RD_RES) begin
        if (slv_err) begin
          gap_cnt <= GAP_W'(RETRY_GAP - 2);
        end else begin
          res_valid[rd_id[ID_SIZE-1 -: IDX_W]] <= 1'b1;
          res_data    <= rdata[DATA_SIZE-1:0];
          res_carry   <= rdata[DATA_SIZE];
          res_id      <= rd_id;
          outstanding <= outstanding - 1'b1;
        end
      end

      if (state == S_BACKOFF && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule
